// File: rtl/sram_like_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_pkg
// Description : Shared definitions for the SRAM-like data interface: access
//               size codes, the response-queue entry layout and the
//               size/address to byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_pkg;

   // Access size codes carried on data_size; 2'b11 behaves as a word.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Width of the per-entry latency countdown (LATENCY is at most 15).
   localparam int unsigned CNT_W = 4;

   // One outstanding response: kind of access and the word captured at accept.
   typedef struct packed {
      logic        is_write;
      logic [31:0] rdata;
   } resp_t;

   // Byte-lane enables for a store of the given size at the given byte offset.
   // Half-word accesses ignore addr_lo[0]; word (and the spare code) enable all lanes.
   function automatic logic [3:0] size_addr_to_mask(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << addr_lo;
         SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_resp_queue.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp_queue
// Description : In-order circular buffer of pending responses. Each entry
//               carries its own countdown that starts at LATENCY-1 on push
//               and decrements every cycle, saturating at zero. The head is
//               ready to retire once its countdown has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_resp_queue
   import sram_like_pkg::*;
#(
   parameter int QDEPTH  = 2,
   parameter int LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  resp_t                   push_data,
   input  logic                    pop,
   output logic                    head_zero,
   output resp_t                   head_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(QDEPTH):0] count
);

   localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW    = $clog2(QDEPTH) + 1;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

   resp_t              entry_data [QDEPTH];
   logic [CNT_W-1:0]   entry_cnt  [QDEPTH];
   logic [PTR_W-1:0]   head_ptr;
   logic [PTR_W-1:0]   tail_ptr;
   logic [CW-1:0]      fill;

   // Wrap a pointer at QDEPTH entries.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(QDEPTH - 1)) begin
         n = '0;
      end else begin
         n = p + 1'b1;
      end
      return n;
   endfunction

   // Head/tail pointers and occupancy; a push and pop together keep the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         fill     <= '0;
      end else begin
         if (push) begin
            tail_ptr <= ptr_next(tail_ptr);
         end
         if (pop) begin
            head_ptr <= ptr_next(head_ptr);
         end
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // Per-entry countdowns: load on push, otherwise count down to zero and hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            entry_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (push && (tail_ptr == PTR_W'(i))) begin
               entry_cnt[i] <= LAT_INIT;
            end else if (entry_cnt[i] != '0) begin
               entry_cnt[i] <= entry_cnt[i] - 1'b1;
            end
         end
      end
   end

   // Entry payload is only meaningful while occupied, so it carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++) begin
         if (push && (tail_ptr == PTR_W'(i))) begin
            entry_data[i] <= push_data;
         end
      end
   end

   assign head_data = entry_data[head_ptr];
   assign head_zero = (entry_cnt[head_ptr] == '0);
   assign full      = (fill == CW'(QDEPTH));
   assign empty     = (fill == '0);
   assign count     = fill;

endmodule
`default_nettype wire

// File: rtl/sram_like_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp_mem
// Description : Word-addressed memory responding on the SRAM-like data
//               interface. Every access is performed at the accept edge;
//               responses come back in order after a fixed LATENCY with up
//               to QDEPTH requests outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_resp_mem
   import sram_like_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2,
   parameter int QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_index;
   logic [3:0]            byte_mask;
   logic                  accept;
   logic                  retire;
   resp_t                 push_data;
   resp_t                 head_data;
   logic                  head_zero;
   logic                  q_full;
   logic                  q_empty;
   logic [$clog2(QDEPTH):0] q_count;
   logic                  unused_bits;

   // Upper address bits alias; only the word index and byte offset matter.
   assign word_index = data_addr[ADDR_WIDTH+1:2];
   assign byte_mask  = size_addr_to_mask(data_size, data_addr[1:0]);

   // A retiring head still holds its slot this cycle, so a full queue never
   // accepts even when it is draining; with QDEPTH == LATENCY that costs one
   // idle cycle per QDEPTH accepts.
   assign data_addr_ok = rst & data_req & ~q_full;
   assign accept       = data_req & data_addr_ok;

   assign data_data_ok = rst & ~q_empty & head_zero;
   assign retire       = data_data_ok;

   // Reads snapshot the whole word now; a write accepted in an earlier cycle
   // is therefore always visible, even if its own response is still pending.
   assign push_data.is_write = data_wr;
   assign push_data.rdata    = data_wr ? 32'h0 : mem[word_index];

   assign data_rdata = (data_data_ok && !head_data.is_write) ? head_data.rdata : 32'h0;

   // Byte-masked store at the accept edge; memory contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && data_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_mask[b]) begin
               mem[word_index][8*b +: 8] <= data_wdata[8*b +: 8];
            end
         end
      end
   end

   sram_like_resp_queue #(
      .QDEPTH  (QDEPTH),
      .LATENCY (LATENCY)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (push_data),
      .pop       (retire),
      .head_zero (head_zero),
      .head_data (head_data),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   assign unused_bits = ^{data_addr[31:ADDR_WIDTH+2], q_count};

endmodule
`default_nettype wire
